// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/sub_borrow.sv
// Combinational N-bit subtract returning difference and borrow-out.
module sub_borrow #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);
  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
endmodule

// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// valid/ready handshakes on operand and result sides.
module div8_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q;
  logic [WIDTH-1:0] q_q, dvs_q, quo_q, rem_q;
  // Partial remainder stays below the divisor, so its top bit is always 0
  // and only WIDTH bits are stored; the subtract itself runs at WIDTH+1.
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dbz_q, vld_q, busy_q;

  logic [WIDTH:0]   t, diff;
  logic             borrow;
  logic [WIDTH-1:0] q_d, r_d;
  logic             unused_msb;

  assign t = {r_q, q_q[WIDTH-1]};

  sub_borrow #(.N(WIDTH + 1)) u_sub (
    .a_i     (t),
    .b_i     ({1'b0, dvs_q}),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  assign r_d        = borrow ? t[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_d        = {q_q[WIDTH-2:0], ~borrow};
  assign unused_msb = diff[WIDTH];

  assign start_ready = (state_q == IDLE);
  assign res_valid   = vld_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              q_q     <= dividend;
              r_q     <= '0;
              dvs_q   <= divisor;
              cnt_q   <= '0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quo_q   <= q_d;
            rem_q   <= r_d;
            vld_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Zero-divisor path enters DONE with valid still low; raise it here.
          if (!vld_q) begin
            vld_q <= 1'b1;
          end else if (res_ready) begin
            vld_q   <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/div8_seq.md
# div8_seq

Sequential unsigned restoring divider: the inverse-direction companion to the 8-bit parallel-prefix adder in the arithmetic datapath. It accepts a dividend/divisor pair over a valid/ready handshake and iterates one quotient bit per clock through a shared subtract-with-borrow stage. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It sits between the user-project register bank and the arithmetic units, alongside the adder.

## Interface
- WIDTH, 8, operand/result width in bits; iteration count equals WIDTH
- wb_clk_i  in  1  single clock, rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- start_valid  in  1  operands valid
- start_ready  out  1  block can accept operands
- dividend  in  WIDTH  unsigned dividend, sampled on accept
- divisor  in  WIDTH  unsigned divisor, sampled on accept
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- quotient  out  WIDTH  unsigned quotient
- remainder  out  WIDTH  unsigned remainder
- div_by_zero  out  1  divisor was zero for this result
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. An accept is start_valid&start_ready at a rising edge.
  - On accept with divisor!=0: load q=dividend, r=0 (WIDTH+1 bits) and the divisor register, set count=0, go to RUN.
  - On accept with divisor==0: go straight to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- RUN, one iteration per edge:
  - t={r[WIDTH-1:0], q[WIDTH-1]}; d=t-{1'b0,divisor}.
  - If there is no borrow: r=d, q={q[WIDTH-2:0],1}.
  - Otherwise: r=t, q={q[WIDTH-2:0],0}.
  - count increments. On the edge completing iteration WIDTH-1, go to DONE.
- DONE: res_valid=1; quotient=q, remainder=r[WIDTH-1:0].
  - Outputs hold stable while res_valid&!res_ready.
  - On res_valid&res_ready: go to IDLE and clear div_by_zero.
- start_ready is 0 outside IDLE. start_valid is ignored in RUN and DONE, so no new accept can occur in the same cycle a result is consumed.
- Operands are fully captured on accept. Input changes after accept have no effect.
- Invariant at DONE (divisor!=0): dividend == quotient*divisor + remainder, and remainder < divisor.

## Timing
- Reset (async assert, release synchronous to wb_clk_i): state=IDLE, start_ready=1, res_valid=0, busy=0, quotient=0, remainder=0, div_by_zero=0, count=0.
- Reset asserted mid-RUN or in DONE aborts immediately. The pending result is discarded and is never presented.
- Latency, divisor!=0: with accept at edge E0, res_valid rises after edge E0+WIDTH (8 cycles for the default).
- Latency, divisor==0: res_valid rises after edge E0+1.
- Throughput:
  - Minimum accept-to-accept spacing is WIDTH+2 cycles: WIDTH in RUN, one in DONE with res_ready=1, one in IDLE.
  - Backpressure extends DONE indefinitely.
- All outputs are registered. No combinational path from any input to any output, except start_ready, which is decoded from state only.

## Structure
- Shared package div_pkg holds:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - WIDTH default
  - counter width constant $clog2(WIDTH)
- Sub-module sub_borrow (parameter N=WIDTH+1):
  - purely combinational a-b returning diff[N-1:0] and borrow
  - instantiated once in the iteration datapath
  - will later be swapped for a prefix-tree subtractor built like the adder
- Top-level holds the FSM, the q/r/divisor/count registers and the output registers.

## Test plan
- dividend=100, divisor=7, res_ready=1 -> res_valid after edge E0+8; quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=3, divisor=200 -> quotient=0, remainder=3.
- dividend=5, divisor=0 -> res_valid after edge E0+1; quotient=0xFF, remainder=5, div_by_zero=1. The next ordinary division returns div_by_zero=0.
- Backpressure: dividend=200, divisor=9 with res_ready=0 for 20 cycles -> quotient=22, remainder=2 held stable, start_ready=0 throughout. Toggling start_valid and the operands has no effect. Raising res_ready gives one transfer, then IDLE.
- Assert wb_rst_i at RUN iteration 4, release, then issue 17/4 -> all outputs at reset values during reset, no stale result, then quotient=4, remainder=1.
- Random sweep of all 65536 operand pairs with random res_ready stalls -> invariant holds, and divisor==0 cases match the zero-divisor rule.
